// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] BUBBLE_PC        = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_INST      = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0004;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/if_fetch_unit_counter.sv
// Free-running up-counter with synchronous active-low clear and increment enable.
module if_counter64 #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory and
// presents one buffered instruction at a time to the IF/ID register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IFID_write,
  input  logic             IF_flush,
  input  logic [31:0]      redirect_pc,
  output logic             im_req,
  output logic [31:0]      im_addr,
  input  logic             im_ready,
  input  logic [31:0]      im_rdata,
  output logic             fetch_valid,
  output logic [31:0]      PC_out,
  output logic [31:0]      Instruction_out,
  output logic [CNT_W-1:0] cycle_out,
  output logic [CNT_W-1:0] instr_out
);

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             valid_q, valid_d;
  logic [31:0]      pc_out_q, pc_out_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] cyc_out_q, cyc_out_d;
  logic [CNT_W-1:0] ord_q, ord_d;

  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             accept;

  assign accept = valid_q & IFID_write & ~IF_flush;

  if_counter64 #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc   (1'b1),
    .count (cycle_cnt)
  );

  if_counter64 #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .clr_n (rst),
    .inc   (accept),
    .count (instr_cnt)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    pc_out_d  = pc_out_q;
    inst_d    = inst_q;
    cyc_out_d = cyc_out_q;
    ord_d     = ord_q;

    unique case (state_q)
      FETCH: begin
        if (im_ready) begin
          if (IF_flush) begin
            pc_d = word_align(redirect_pc);
          end else begin
            valid_d   = 1'b1;
            pc_out_d  = pc_q;
            inst_d    = im_rdata;
            cyc_out_d = cycle_cnt;
            ord_d     = instr_cnt + CNT_W'(1);
            state_d   = HOLD;
          end
        end else if (IF_flush) begin
          // The in-flight request cannot be withdrawn; wait it out in DRAIN.
          pc_d    = word_align(redirect_pc);
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (IF_flush || accept) begin
          valid_d   = 1'b0;
          pc_out_d  = BUBBLE_PC;
          inst_d    = BUBBLE_INST;
          cyc_out_d = '0;
          ord_d     = '0;
          state_d   = FETCH;
          pc_d      = IF_flush ? word_align(redirect_pc) : pc_q + PC_STEP;
        end
      end
      DRAIN: begin
        if (IF_flush) begin
          pc_d = word_align(redirect_pc);
        end
        if (im_ready) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // The request address only follows pc when a fresh request starts, so a
    // draining request keeps its stale address on the bus.
    req_addr_d = (state_d == FETCH) ? pc_d : req_addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      valid_q    <= 1'b0;
      pc_out_q   <= BUBBLE_PC;
      inst_q     <= BUBBLE_INST;
      cyc_out_q  <= '0;
      ord_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
      pc_out_q   <= pc_out_d;
      inst_q     <= inst_d;
      cyc_out_q  <= cyc_out_d;
      ord_q      <= ord_d;
    end
  end

  // Memory shares this reset, so the request is masked while reset is held.
  assign im_req          = rst & ((state_q == FETCH) | (state_q == DRAIN));
  assign im_addr         = req_addr_q;
  assign fetch_valid     = valid_q;
  assign PC_out          = pc_out_q;
  assign Instruction_out = inst_q;
  assign cycle_out       = cyc_out_q;
  assign instr_out       = ord_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: random memory latency, stalls and redirects.
module tb_if_fetch_unit;

  localparam int          CNT_W  = 64;
  localparam logic [31:0] RST_PC = 32'h0000_0004;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             IFID_write = 1'b0;
  logic             IF_flush = 1'b0;
  logic [31:0]      redirect_pc = 32'h0;
  logic             im_req;
  logic [31:0]      im_addr;
  logic             im_ready = 1'b0;
  logic [31:0]      im_rdata = 32'h0;
  logic             fetch_valid;
  logic [31:0]      PC_out;
  logic [31:0]      Instruction_out;
  logic [CNT_W-1:0] cycle_out;
  logic [CNT_W-1:0] instr_out;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .IFID_write      (IFID_write),
    .IF_flush        (IF_flush),
    .redirect_pc     (redirect_pc),
    .im_req          (im_req),
    .im_addr         (im_addr),
    .im_ready        (im_ready),
    .im_rdata        (im_rdata),
    .fetch_valid     (fetch_valid),
    .PC_out          (PC_out),
    .Instruction_out (Instruction_out),
    .cycle_out       (cycle_out),
    .instr_out       (instr_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: an odd multiplier keeps every address's word distinct.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h9E37_79B1;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [63:0] ord;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc  = RST_PC;
  logic [63:0] model_ord = 64'd0;

  // Reference cycle count: zero during the first cycle after reset.
  logic [63:0] tb_cyc = 64'd0;
  always @(posedge clk) tb_cyc <= rst ? tb_cyc + 64'd1 : 64'd0;

  // Memory model with random response latency.
  int          mem_min = 0;
  int          mem_max = 0;
  int          mem_wait = -1;
  logic [63:0] last_ready_cyc = 64'd0;

  always @(negedge clk) begin
    #1;
    im_ready = 1'b0;
    if (!rst) begin
      mem_wait = -1;
    end else if (im_req) begin
      if (mem_wait < 0) mem_wait = int'($urandom_range(mem_max, mem_min));
      if (mem_wait == 0) begin
        im_ready       = 1'b1;
        im_rdata       = memf(im_addr);
        last_ready_cyc = tb_cyc;
        mem_wait       = -1;
      end else begin
        mem_wait--;
      end
    end
  end

  // Monitor: checks every cycle, pops the scoreboard on each accepted instruction.
  int          accepted = 0;
  logic [63:0] last_acc_cout = 64'd0;
  logic        p_rst = 1'b1, p_valid = 1'b0, p_wr = 1'b0, p_fl = 1'b0;
  logic [31:0] p_pc = 32'h0, p_inst = 32'h0;
  logic [63:0] p_cyc = 64'd0, p_ord = 64'd0;

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      accepted = 0;
      chk("im_req_in_reset", {63'd0, im_req}, 64'd0);
    end
    if (!p_rst) begin
      chk("reset_valid", {63'd0, fetch_valid}, 64'd0);
      chk("reset_outputs", {32'd0, PC_out | Instruction_out} | cycle_out | instr_out, 64'd0);
    end
    if (rst) begin
      chk("im_req_vs_valid", {63'd0, im_req}, {63'd0, ~fetch_valid});
      chk("im_addr_align", {62'd0, im_addr[1:0]}, 64'd0);
      if (p_rst && p_valid && !p_wr && !p_fl) begin
        chk("stall_valid", {63'd0, fetch_valid}, 64'd1);
        chk("stall_pc", {32'd0, PC_out}, {32'd0, p_pc});
        chk("stall_inst", {32'd0, Instruction_out}, {32'd0, p_inst});
        chk("stall_cycle", cycle_out, p_cyc);
        chk("stall_instr", instr_out, p_ord);
      end
      if (p_rst && p_fl) chk("flush_drops_valid", {63'd0, fetch_valid}, 64'd0);
      if (!fetch_valid)
        chk("bubble_zero", {32'd0, PC_out | Instruction_out} | cycle_out | instr_out, 64'd0);
      if (fetch_valid && IFID_write && !IF_flush) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_accept: got PC 0x%0h, expected no instruction", PC_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("acc_pc", {32'd0, PC_out}, {32'd0, e.pc});
          chk("acc_inst", {32'd0, Instruction_out}, {32'd0, memf(e.pc)});
          chk("acc_cycle", cycle_out, last_ready_cyc);
          chk("acc_ordinal", instr_out, e.ord);
        end
        last_acc_cout = cycle_out;
        accepted++;
      end
    end
    p_rst = rst; p_valid = fetch_valid; p_wr = IFID_write; p_fl = IF_flush;
    p_pc = PC_out; p_inst = Instruction_out; p_cyc = cycle_out; p_ord = instr_out;
  end

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      model_ord = model_ord + 64'd1;
      exp_q.push_back('{pc: model_pc, ord: model_ord});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic wait_accepts(input int target, input int wr_pct);
    int budget = 400;
    forever begin
      @(negedge clk);
      if (accepted >= target || budget == 0) break;
      budget--;
      IFID_write = (int'($urandom_range(99, 0)) < wr_pct);
    end
    IFID_write = 1'b0;
    chk("accept_count", 64'(accepted), 64'(target));
    if (accepted < target) exp_q.delete();
  endtask

  task automatic run_accepts(input int n, input int wr_pct);
    int target;
    target = accepted + n;
    push_n(n);
    wait_accepts(target, wr_pct);
  endtask

  task automatic wait_valid();
    int budget = 100;
    while (!fetch_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("wait_valid", {63'd0, fetch_valid}, 64'd1);
  endtask

  task automatic wait_fetching();
    int budget = 100;
    while (!(im_req && !fetch_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("wait_fetching", {63'd0, im_req & ~fetch_valid}, 64'd1);
  endtask

  task automatic do_flush(input logic [31:0] tgt, input logic wr);
    IF_flush    = 1'b1;
    redirect_pc = tgt;
    IFID_write  = wr;
    model_pc    = tgt & ~32'd3;
    @(negedge clk);
    IF_flush    = 1'b0;
    IFID_write  = 1'b0;
    redirect_pc = $urandom;
  endtask

  task automatic do_flush2(input logic [31:0] t1, input logic [31:0] t2, input logic wr);
    IF_flush    = 1'b1;
    redirect_pc = t1;
    IFID_write  = wr;
    @(negedge clk);
    redirect_pc = t2;
    model_pc    = t2 & ~32'd3;
    @(negedge clk);
    IF_flush    = 1'b0;
    IFID_write  = 1'b0;
    redirect_pc = $urandom;
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_pc  = RST_PC;
    model_ord = 64'd0;
  endtask

  initial begin
    logic [31:0] hold_pc;
    logic [31:0] tgt;

    // Reset held for three edges, then zero-wait fetch from RESET_PC.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    push_n(3);
    rst        = 1'b1;
    IFID_write = 1'b1;
    #3;
    chk("t1_im_req", {63'd0, im_req}, 64'd1);
    chk("t1_im_addr", {32'd0, im_addr}, {32'd0, RST_PC});
    @(negedge clk);
    #3;
    chk("t1_valid", {63'd0, fetch_valid}, 64'd1);
    chk("t1_pc", {32'd0, PC_out}, {32'd0, RST_PC});
    chk("t1_instr", instr_out, 64'd1);
    chk("t1_cycle", cycle_out, 64'd0);
    wait_accepts(3, 100);
    chk("t2_third_stamp", last_acc_cout, 64'd4);

    // Stall in HOLD, then release and look at the next request address.
    wait_valid();
    hold_pc = PC_out;
    repeat (5) @(negedge clk);
    chk("t3_pc_held", {32'd0, PC_out}, {32'd0, hold_pc});
    chk("t3_instr_held", instr_out, 64'd4);
    push_n(1);
    IFID_write = 1'b1;
    @(negedge clk);
    IFID_write = 1'b0;
    #3;
    chk("t3_next_addr", {32'd0, im_addr}, {32'd0, hold_pc + 32'd4});
    mem_max = 3;
    run_accepts(5, 60);

    // Redirect while stalled in HOLD.
    wait_valid();
    do_flush(32'h0000_0103, 1'b0);
    #3;
    chk("t4_valid_zero", {63'd0, fetch_valid}, 64'd0);
    chk("t4_next_addr", {32'd0, im_addr}, 64'h100);
    run_accepts(3, 80);

    // Redirect during a slow fetch: stale word must be drained and dropped.
    mem_min = 3;
    mem_max = 3;
    wait_fetching();
    do_flush(32'h0000_2002, 1'b0);
    wait_valid();
    chk("t5_target_pc", {32'd0, PC_out}, 64'h2000);
    chk("t5_target_inst", {32'd0, Instruction_out}, {32'd0, memf(32'h2000)});
    run_accepts(3, 80);

    // Reset while a drained request is still pending.
    wait_fetching();
    do_flush(32'h0000_3000, 1'b0);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    push_n(1);
    mem_min = 0;
    mem_max = 0;
    rst = 1'b1;
    @(negedge clk);
    #3;
    chk("t6_pc", {32'd0, PC_out}, {32'd0, RST_PC});
    chk("t6_cycle", cycle_out, 64'd0);
    chk("t6_instr", instr_out, 64'd1);
    wait_accepts(1, 100);
    mem_max = 2;
    run_accepts(3, 70);

    // Randomized redirects at arbitrary points in the fetch protocol.
    for (int s = 0; s < 12; s++) begin
      int mode;
      mem_min = 0;
      mem_max = int'($urandom_range(3, 0));
      mode = int'($urandom_range(2, 0));
      if (mode == 0) wait_valid();
      else if (mode == 1) wait_fetching();
      else repeat ($urandom_range(3, 0)) @(negedge clk);
      tgt = $urandom_range(32'h00FF_FFFF, 32'h0000_0200);
      if ($urandom_range(1, 0) == 1)
        do_flush2($urandom_range(32'h00FF_FFFF, 32'h200), tgt, 1'($urandom_range(1, 0)));
      else
        do_flush(tgt, 1'($urandom_range(1, 0)));
      run_accepts(int'($urandom_range(6, 2)), 70);
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
